inst_dec_stage: RTL and testbench
=================================

# inst_dec_stage

Registered RV32I instruction-decode pipeline stage with a valid/ready handshake and a parametrised output queue. It sits between instruction fetch and register read/execute. Each cycle it decodes one fetched word into an operation class, an ALU/branch function, register indices, a sign-extended immediate and an illegal flag, then buffers the result so fetch and execute can stall independently. A flush input discards queued and in-flight decodes on redirect.

## Interface
- DEPTH, 2 — output queue entries; power of two, ≥2
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_flush  in  1  drop all queued entries and the current input
- i_valid  in  1  fetch word valid
- o_ready  out  1  stage can accept (registered)
- i_inst_data  in  32  instruction word
- i_pc  in  32  PC of instruction
- o_valid  out  1  head entry valid
- i_ready  in  1  downstream accepts head
- o_op_mode  out  3  operation class
- o_func_op  out  3  function within class
- o_fp_mode  out  1  floating-point op; always 0 in this block
- o_br  out  1  conditional branch, not set-less-than
- o_rd / o_rs1 / o_rs2  out  5 each  register indices; 0 when unused
- o_imm  out  32  sign-extended immediate
- o_pc  out  32  PC of head entry
- o_illegal  out  1  undecodable or disabled encoding

## Operation
- Accept when i_valid && o_ready && !i_flush; decode combinationally, push into queue.
- o_op_mode:
  - 0 = upper/jump; o_func_op 000 LUI, 001 AUIPC, 010 JAL, 011 JALR.
  - 1 = LOAD and 2 = STORE; o_func_op = funct3.
  - 3 = compare; o_func_op 000 LT, 001 LTU, 010 GEU, 011 GE, 100 NE, 101 EQ.
    - B-type sets o_br=1.
    - SLT/SLTI map to LT; SLTU/SLTIU map to LTU; o_br=0.
  - 4 = arith; 000 ADD/ADDI, 001 SUB.
  - 5 = logic/shift; 000 XOR, 001 OR, 010 AND, 011 SLL, 100 SRL, 101 SRA.
  - 6 = mul/div; o_func_op = funct3.
  - 7 = system; 000 ECALL, 001 EBREAK.
- Immediate formats:
  - I: inst[31:20], sign-extended.
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R-type: 0.
- Shift-immediate: imm = shamt inst[24:20]. inst[30] selects SRA vs SRL. Any other funct7 bit set → illegal.
- Illegal: unknown opcode, reserved funct3 (branch 010/011, load 011/110/111, store ≥011), bad funct7, SYSTEM other than exact ECALL/EBREAK.
  - Illegal entries are queued with o_illegal=1, op_mode=7, func_op=111, rd/rs1/rs2=0.
- Queue: circular, DEPTH entries; count width $clog2(DEPTH)+1. Pointers wrap modulo DEPTH.

## Timing
- Reset: o_valid=0, o_ready=1, pointers/count=0, all data outputs 0.
- Latency: a word accepted in cycle N is visible at o_valid in N+1 when the queue is empty.
- o_ready is registered and equals count<DEPTH after the cycle's push/pop. It never depends combinationally on i_ready.
- Full (count==DEPTH): o_ready=0. A pop in that cycle raises o_ready the next cycle; no same-cycle push.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, order preserved.
- Empty: o_valid=0. Data outputs hold the last popped values.
- Outputs hold stable while o_valid && !i_ready.
- i_flush: next cycle count=0, o_valid=0, o_ready=1. The input presented during the flush cycle is dropped. Flush has priority over push/pop.
- i_rst mid-stream: identical to flush plus all data outputs cleared.

## Configuration
- RV32M_EN defined: R-type with funct7=0000001 decodes as op_mode=6, func_op=funct3 (MUL…REMU).
- RV32M_EN undefined: that encoding is illegal (o_illegal=1); no op_mode=6 output is ever produced.

## Test plan
- Reset, then ADDI x5,x0,-1 (0xFFF00293) at pc 0x100 → next cycle o_valid=1, op_mode=4, func_op=000, rd=5, rs1=0, imm=0xFFFFFFFF, o_pc=0x100.
- BEQ x1,x2,+8 (0x00208463) → op_mode=3, func_op=101, o_br=1, rs1=1, rs2=2, rd=0, imm=8.
- DEPTH=2, i_ready=0, push 3 words → o_ready drops after the 2nd push; 3rd is not accepted. Raise i_ready → drains in order, o_ready returns to 1.
- Queue holding 2 entries, i_flush pulsed together with i_valid → next cycle o_valid=0, count=0, flushed word absent.
- MUL x3,x1,x2 (0x022081B3) → with RV32M_EN: op_mode=6, func_op=000. Without: o_illegal=1, op_mode=7, func_op=111.
- Illegal opcode 0x0000007F and SRAI with funct7=0x40 (0x4050D093) → first o_illegal=1; second op_mode=5, func_op=101, imm=5.

Source files
------------

// File: rtl/inst_dec_stage.sv
// inst_dec_stage: registered RV32I decode stage with a DEPTH-entry output queue.
// Each accepted fetch word is decoded in the same cycle and pushed into the queue.
// Optional feature: define RV32M_EN to decode the M extension (op_mode 6);
// without it those encodings are reported as illegal.
module inst_dec_stage #(
    parameter int DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_flush,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_inst_data,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [2:0]  o_op_mode,
    output logic [2:0]  o_func_op,
    output logic        o_fp_mode,
    output logic        o_br,
    output logic [4:0]  o_rd,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [31:0] o_imm,
    output logic [31:0] o_pc,
    output logic        o_illegal
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [2:0]  op_mode;
        logic [2:0]  func_op;
        logic        br;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        illegal;
    } entry_t;

    entry_t         mem [DEPTH];
    entry_t         dec_next;
    entry_t         last_reg;
    entry_t         head;
    logic [PW-1:0]  rd_ptr_reg;
    logic [PW-1:0]  wr_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic [CW-1:0]  count_next;
    logic           ready_reg;
    logic           push;
    logic           pop;
    logic           bad;

    wire [6:0] opcode = i_inst_data[6:0];
    wire [2:0] funct3 = i_inst_data[14:12];
    wire [6:0] funct7 = i_inst_data[31:25];
    wire [4:0] f_rd   = i_inst_data[11:7];
    wire [4:0] f_rs1  = i_inst_data[19:15];
    wire [4:0] f_rs2  = i_inst_data[24:20];

    wire [31:0] imm_i = {{20{i_inst_data[31]}}, i_inst_data[31:20]};
    wire [31:0] imm_s = {{20{i_inst_data[31]}}, i_inst_data[31:25], i_inst_data[11:7]};
    wire [31:0] imm_b = {{19{i_inst_data[31]}}, i_inst_data[31], i_inst_data[7],
                         i_inst_data[30:25], i_inst_data[11:8], 1'b0};
    wire [31:0] imm_u = {i_inst_data[31:12], 12'b0};
    wire [31:0] imm_j = {{11{i_inst_data[31]}}, i_inst_data[31], i_inst_data[19:12],
                         i_inst_data[20], i_inst_data[30:21], 1'b0};

    // Combinational decode of the presented fetch word into a queue entry
    always_comb begin
        dec_next    = '0;
        dec_next.pc = i_pc;
        bad         = 1'b0;
        case (opcode)
            7'b0110111: begin dec_next.func_op = 3'd0; dec_next.rd = f_rd; dec_next.imm = imm_u; end
            7'b0010111: begin dec_next.func_op = 3'd1; dec_next.rd = f_rd; dec_next.imm = imm_u; end
            7'b1101111: begin dec_next.func_op = 3'd2; dec_next.rd = f_rd; dec_next.imm = imm_j; end
            7'b1100111: begin
                dec_next.func_op = 3'd3; dec_next.rd = f_rd; dec_next.rs1 = f_rs1; dec_next.imm = imm_i;
            end
            7'b0000011: begin
                dec_next.op_mode = 3'd1; dec_next.func_op = funct3;
                dec_next.rd = f_rd; dec_next.rs1 = f_rs1; dec_next.imm = imm_i;
                bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            7'b0100011: begin
                dec_next.op_mode = 3'd2; dec_next.func_op = funct3;
                dec_next.rs1 = f_rs1; dec_next.rs2 = f_rs2; dec_next.imm = imm_s;
                bad = (funct3 >= 3'b011);
            end
            7'b1100011: begin
                dec_next.op_mode = 3'd3; dec_next.br = 1'b1;
                dec_next.rs1 = f_rs1; dec_next.rs2 = f_rs2; dec_next.imm = imm_b;
                case (funct3)
                    3'b000:  dec_next.func_op = 3'd5;   // BEQ  -> EQ
                    3'b001:  dec_next.func_op = 3'd4;   // BNE  -> NE
                    3'b100:  dec_next.func_op = 3'd0;   // BLT  -> LT
                    3'b101:  dec_next.func_op = 3'd3;   // BGE  -> GE
                    3'b110:  dec_next.func_op = 3'd1;   // BLTU -> LTU
                    3'b111:  dec_next.func_op = 3'd2;   // BGEU -> GEU
                    default: bad = 1'b1;
                endcase
            end
            7'b0010011: begin
                dec_next.rd = f_rd; dec_next.rs1 = f_rs1; dec_next.imm = imm_i;
                case (funct3)
                    3'b000: begin dec_next.op_mode = 3'd4; dec_next.func_op = 3'd0; end
                    3'b010: begin dec_next.op_mode = 3'd3; dec_next.func_op = 3'd0; end
                    3'b011: begin dec_next.op_mode = 3'd3; dec_next.func_op = 3'd1; end
                    3'b100: begin dec_next.op_mode = 3'd5; dec_next.func_op = 3'd0; end
                    3'b110: begin dec_next.op_mode = 3'd5; dec_next.func_op = 3'd1; end
                    3'b111: begin dec_next.op_mode = 3'd5; dec_next.func_op = 3'd2; end
                    3'b001: begin
                        dec_next.op_mode = 3'd5; dec_next.func_op = 3'd3;
                        dec_next.imm = {27'b0, f_rs2};
                        bad = (funct7 != 7'b0);
                    end
                    default: begin
                        // SRLI/SRAI: only bit 30 may be set in the funct7 field
                        dec_next.op_mode = 3'd5;
                        dec_next.func_op = i_inst_data[30] ? 3'd5 : 3'd4;
                        dec_next.imm = {27'b0, f_rs2};
                        bad = ({funct7[6], funct7[4:0]} != 6'b0);
                    end
                endcase
            end
            7'b0110011: begin
                dec_next.rd = f_rd; dec_next.rs1 = f_rs1; dec_next.rs2 = f_rs2;
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000: begin dec_next.op_mode = 3'd4; dec_next.func_op = 3'd0; end
                            3'b001: begin dec_next.op_mode = 3'd5; dec_next.func_op = 3'd3; end
                            3'b010: begin dec_next.op_mode = 3'd3; dec_next.func_op = 3'd0; end
                            3'b011: begin dec_next.op_mode = 3'd3; dec_next.func_op = 3'd1; end
                            3'b100: begin dec_next.op_mode = 3'd5; dec_next.func_op = 3'd0; end
                            3'b101: begin dec_next.op_mode = 3'd5; dec_next.func_op = 3'd4; end
                            3'b110: begin dec_next.op_mode = 3'd5; dec_next.func_op = 3'd1; end
                            default: begin dec_next.op_mode = 3'd5; dec_next.func_op = 3'd2; end
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000) begin
                            dec_next.op_mode = 3'd4; dec_next.func_op = 3'd1;
                        end else if (funct3 == 3'b101) begin
                            dec_next.op_mode = 3'd5; dec_next.func_op = 3'd5;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    7'b0000001: begin
`ifdef RV32M_EN
                        dec_next.op_mode = 3'd6; dec_next.func_op = funct3;
`else
                        bad = 1'b1;
`endif
                    end
                    default: bad = 1'b1;
                endcase
            end
            7'b1110011: begin
                dec_next.op_mode = 3'd7;
                if (i_inst_data == 32'h0000_0073)      dec_next.func_op = 3'd0;
                else if (i_inst_data == 32'h0010_0073) dec_next.func_op = 3'd1;
                else                                   bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            dec_next         = '0;
            dec_next.pc      = i_pc;
            dec_next.op_mode = 3'd7;
            dec_next.func_op = 3'd7;
            dec_next.illegal = 1'b1;
        end
    end

    assign o_valid    = (count_reg != '0);
    assign o_ready    = ready_reg;
    assign push       = i_valid && ready_reg && !i_flush && !i_rst;
    assign pop        = o_valid && i_ready;
    assign count_next = count_reg + CW'(push) - CW'(pop);

    // Queue storage: write the decoded entry at the tail on every accepted word
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= dec_next;
        end
    end

    // Pointer/count bookkeeping, registered ready, and the last-popped holding copy
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b1;
            last_reg   <= '0;
        end else if (i_flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b1;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                last_reg   <= mem[rd_ptr_reg];
            end
            count_reg <= count_next;
            ready_reg <= (count_next < CW'(DEPTH));
        end
    end

    // Head entry when occupied; otherwise keep showing the last entry handed downstream
    assign head      = o_valid ? mem[rd_ptr_reg] : last_reg;
    assign o_op_mode = head.op_mode;
    assign o_func_op = head.func_op;
    assign o_fp_mode = 1'b0;
    assign o_br      = head.br;
    assign o_rd      = head.rd;
    assign o_rs1     = head.rs1;
    assign o_rs2     = head.rs2;
    assign o_imm     = head.imm;
    assign o_pc      = head.pc;
    assign o_illegal = head.illegal;
endmodule

// File: tb/tb_inst_dec_stage.sv
// Bench for inst_dec_stage: directed vectors with hand-decoded expectations,
// a transaction-level queue model, and a per-cycle compare of every output.
module tb_inst_dec_stage;
    localparam int DEPTH = 2;
    localparam int NV    = 14;

    typedef struct packed {
        logic [2:0]  op;
        logic [2:0]  fn;
        logic        br;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        ill;
        logic [31:0] pc;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst, flush, i_valid, i_ready;
    logic [31:0] inst, pc;
    logic        o_ready, o_valid, o_fp_mode, o_br, o_illegal;
    logic [2:0]  o_op_mode, o_func_op;
    logic [4:0]  o_rd, o_rs1, o_rs2;
    logic [31:0] o_imm, o_pc;

    int   checks = 0;
    int   failures = 0;
    int   cur_vec = 0;
    bit   chk_en = 0;
    bit   rnd_rdy = 0;
    rec_t mq[$];
    rec_t m_last;
    rec_t r;
    bit   m_ready, m_acc, do_pop, do_push;
    logic [31:0] insts [NV];

    always #5 clk = ~clk;

    inst_dec_stage #(.DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(i_valid), .o_ready(o_ready),
        .i_inst_data(inst), .i_pc(pc), .o_valid(o_valid), .i_ready(i_ready),
        .o_op_mode(o_op_mode), .o_func_op(o_func_op), .o_fp_mode(o_fp_mode), .o_br(o_br),
        .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_imm(o_imm), .o_pc(o_pc),
        .o_illegal(o_illegal)
    );

    // Hand-decoded expectation for each directed vector (pc filled in on push)
    function automatic rec_t exp_of(int i);
        rec_t e;
        rec_t ill;
        ill = '0; ill.op = 3'd7; ill.fn = 3'd7; ill.ill = 1'b1;
        e = '0;
        case (i)
            0:  begin e.op = 4; e.fn = 0; e.rd = 5; e.imm = 32'hFFFF_FFFF; end  // ADDI x5,x0,-1
            1:  begin e.op = 3; e.fn = 5; e.br = 1; e.rs1 = 1; e.rs2 = 2; e.imm = 8; end // BEQ
`ifdef RV32M_EN
            2:  begin e.op = 6; e.fn = 0; e.rd = 3; e.rs1 = 1; e.rs2 = 2; end   // MUL
`else
            2:  e = ill;
`endif
            3:  e = ill;                                                         // opcode 7F
            4:  begin e.op = 5; e.fn = 5; e.rd = 1; e.rs1 = 1; e.imm = 5; end    // SRAI
            5:  begin e.op = 0; e.fn = 0; e.rd = 7; e.imm = 32'h1234_5000; end   // LUI
            6:  begin e.op = 2; e.fn = 2; e.rs1 = 1; e.rs2 = 2; e.imm = 12; end  // SW
            7:  begin e.op = 4; e.fn = 1; e.rd = 4; e.rs1 = 5; e.rs2 = 6; end    // SUB
            8:  begin e.op = 7; e.fn = 0; end                                    // ECALL
            9:  begin e.op = 0; e.fn = 2; e.rd = 1; e.imm = 32'hFFFF_FFFC; end   // JAL -4
            10: e = ill;                                                         // load f3=011
            11: begin e.op = 3; e.fn = 1; e.rd = 1; e.rs1 = 2; e.imm = 1; end    // SLTIU
            12: e = ill;                                                         // SRLI f7=01
            default: begin e.op = 1; e.fn = 2; e.rd = 1; e.rs1 = 2; e.imm = 32'hFFFF_FFFC; end // LW
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=0x%08h required=0x%08h", name, $time, act, exp);
        end
    endtask

    // Transaction model: queue of expected entries driven by the handshake rules
    always @(posedge clk) begin
        m_acc = 1'b0;
        if (rst) begin
            mq.delete(); m_ready = 1'b1; m_last = '0;
        end else if (flush) begin
            mq.delete(); m_ready = 1'b1;
        end else begin
            do_pop  = (mq.size() != 0) && i_ready;
            do_push = i_valid && m_ready;
            if (do_pop) m_last = mq.pop_front();
            if (do_push) begin
                r = exp_of(cur_vec); r.pc = pc; mq.push_back(r); m_acc = 1'b1;
            end
            m_ready = (mq.size() < DEPTH);
        end
    end

    // Compare every output against the model on each falling edge
    always @(negedge clk) begin
        rec_t e;
        if (chk_en) begin
            e = (mq.size() != 0) ? mq[0] : m_last;
            chk("o_valid", {31'b0, o_valid}, {31'b0, mq.size() != 0});
            chk("o_ready", {31'b0, o_ready}, {31'b0, m_ready});
            chk("op_mode", {29'b0, o_op_mode}, {29'b0, e.op});
            chk("func_op", {29'b0, o_func_op}, {29'b0, e.fn});
            chk("br", {31'b0, o_br}, {31'b0, e.br});
            chk("fp_mode", {31'b0, o_fp_mode}, 32'd0);
            chk("regs", {17'b0, o_rd, o_rs1, o_rs2}, {17'b0, e.rd, e.rs1, e.rs2});
            chk("imm", o_imm, e.imm);
            chk("pc", o_pc, e.pc);
            chk("illegal", {31'b0, o_illegal}, {31'b0, e.ill});
        end
    end

    task automatic send(input int v, input logic [31:0] p);
        int n;
        cur_vec = v; inst = insts[v]; pc = p; i_valid = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            if (rnd_rdy) i_ready = 1'($urandom_range(0, 1));
            n++;
        end while (!m_acc && n < 40);
        if (!m_acc) chk("accept_timeout", 32'd0, 32'd1);
        $display("tx vec=%0d inst=0x%08h pc=0x%08h cycles=%0d", v, insts[v], p, n);
        i_valid = 1'b0;
    endtask

    initial begin
        insts[0]  = 32'hFFF0_0293; insts[1]  = 32'h0020_8463; insts[2]  = 32'h0220_81B3;
        insts[3]  = 32'h0000_007F; insts[4]  = 32'h4050_D093; insts[5]  = 32'h1234_53B7;
        insts[6]  = 32'h0020_A623; insts[7]  = 32'h4062_8233; insts[8]  = 32'h0000_0073;
        insts[9]  = 32'hFFDF_F0EF; insts[10] = 32'h0001_3083; insts[11] = 32'h0011_3093;
        insts[12] = 32'h0210_D093; insts[13] = 32'hFFC1_2083;
        rst = 1'b1; flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1; inst = '0; pc = '0;
        @(posedge clk); #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_ready", {31'b0, o_ready}, 32'd1);
        chk("rst_imm", o_imm, 32'd0);
        #1 rst = 1'b0;

        // ADDI then BEQ with literal expectations
        @(posedge clk); #1;
        send(0, 32'h100);
        @(negedge clk);
        chk("addi_valid", {31'b0, o_valid}, 32'd1);
        chk("addi_op", {29'b0, o_op_mode}, 32'd4);
        chk("addi_rd", {27'b0, o_rd}, 32'd5);
        chk("addi_imm", o_imm, 32'hFFFF_FFFF);
        chk("addi_pc", o_pc, 32'h100);
        @(posedge clk); #1;
        send(1, 32'h104);
        @(negedge clk);
        chk("beq_func", {29'b0, o_func_op}, 32'd5);
        chk("beq_br", {31'b0, o_br}, 32'd1);
        chk("beq_imm", o_imm, 32'd8);

        // Stream all vectors back to back
        for (int i = 0; i < NV; i++) send(i, 32'h200 + 32'(4 * i));
        repeat (3) @(posedge clk); #1;

        // Fill, stall, refuse a third word, then drain in order
        i_ready = 1'b0;
        send(4, 32'h300);
        send(5, 32'h304);
        @(negedge clk);
        chk("full_ready", {31'b0, o_ready}, 32'd0);
        chk("full_head_pc", o_pc, 32'h300);
        @(posedge clk); #1;
        cur_vec = 6; inst = insts[6]; pc = 32'h308; i_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stall_hold_pc", o_pc, 32'h300);
        #1 i_ready = 1'b1;
        send(6, 32'h308);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("drain_valid", {31'b0, o_valid}, 32'd0);
        chk("drain_ready", {31'b0, o_ready}, 32'd1);
        chk("drain_last_pc", o_pc, 32'h308);

        // Flush with a full queue and a word presented during the flush
        @(posedge clk); #1;
        i_ready = 1'b0;
        send(7, 32'h400);
        send(8, 32'h404);
        cur_vec = 9; inst = insts[9]; pc = 32'h408; i_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0; i_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", {31'b0, o_valid}, 32'd0);
        chk("flush_ready", {31'b0, o_ready}, 32'd1);
        // Flush with one entry while the stage is ready: the flush-cycle word must vanish
        @(posedge clk); #1;
        send(10, 32'h500);
        cur_vec = 11; inst = insts[11]; pc = 32'h504; i_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("flush1_valid", {31'b0, o_valid}, 32'd0);

        // Reset in the middle of a stream clears data outputs
        #1 i_ready = 1'b0;
        send(5, 32'h600);
        send(13, 32'h604);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_valid", {31'b0, o_valid}, 32'd0);
        chk("mrst_pc", o_pc, 32'd0);
        chk("mrst_imm", o_imm, 32'd0);

        // Randomised downstream backpressure over the whole table
        rnd_rdy = 1'b1;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NV; i++) send(i, 32'h1000 + 32'(4 * (i + NV * k)));
        rnd_rdy = 1'b0;
        i_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("final_empty", {31'b0, o_valid}, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
